// File: rtl/mem_arbiter.sv
// Two-port to one-memory arbiter for the CPU's fetch and data ports.
// Data wins contention unless fetch has been passed over STARVE_LIMIT times in a row.
// Hung accesses are aborted after TIMEOUT cycles and flagged on bus_err.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // unified memory
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // status
  output logic        bus_err,
  output logic        cpu_stall
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [7:0] TmoMax    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        bus_err_q, bus_err_d;

  logic        grant_d;
  logic        grant_i;
  logic        busy;

  // Arbitration: data has priority unless fetch is pending and has hit the starvation limit.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && !(if_req && (starve_q == StarveMax))) begin
      grant_d = 1'b1;
    end else if (if_req) begin
      grant_i = 1'b1;
    end
  end

  assign busy = (state_q == StBusyI) || (state_q == StBusyD);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    bus_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d   = StBusyD;
          tmo_d     = 8'd0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // Only a data grant that actually passes over a waiting fetch counts.
          if (!if_req) begin
            starve_d = 4'd0;
          end else if (starve_q < StarveMax) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_i) begin
          state_d   = StBusyI;
          tmo_d     = 8'd0;
          starve_d  = 4'd0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = 32'h0;
        end
      end

      StBusyI, StBusyD: begin
        // An ack in the timeout cycle still counts as a clean completion.
        if (m_ack || (tmo_q == TmoMax)) begin
          state_d   = StDone;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_addr_d  = 32'h0;
          m_wdata_d = 32'h0;
          bus_err_d = !m_ack;
          if (state_q == StBusyI) begin
            if_ready_d = 1'b1;
            if_rdata_d = m_ack ? m_rdata : 32'h0;
          end else begin
            d_ready_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_ack ? m_rdata : 32'h0;
            end
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= 4'd0;
      tmo_q      <= 8'd0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= 32'h0;
      m_wdata_q  <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      tmo_q      <= busy || (state_d != StIdle) ? tmo_d : 8'd0;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign bus_err  = bus_err_q;

  // Freeze the pipeline while any request is outstanding and not completing this cycle.
  assign cpu_stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for stray ack, contention/starvation, timeout and reset.
module tb_mem_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned Timeout     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;
  logic        cpu_stall;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT(StarveLimit),
    .TIMEOUT     (Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .bus_err  (bus_err),
    .cpu_stall(cpu_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay extra BUSY cycles; force_ack injects a stray ack.
  bit          mem_en    = 1'b1;
  int          ack_delay = 0;
  logic [31:0] mem_data  = 32'h0;
  bit          force_ack = 1'b0;

  initial begin
    int cyc;
    cyc     = 0;
    m_ack   = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_ack   = 1'b0;
      m_rdata = 32'h0;
      if (force_ack) begin
        m_ack   = 1'b1;
        m_rdata = mem_data;
      end else if (!rst && m_req && mem_en) begin
        if (cyc == ack_delay) begin
          m_ack   = 1'b1;
          m_rdata = mem_data;
          cyc     = 0;
        end else begin
          cyc++;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  // One complete access from IDLE; returns with the DUT back in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    int  lat;
    int  req_cycles;
    bit  done;
    bit  first;
    @(negedge clk);
    mem_en    = 1'b1;
    ack_delay = v.delay;
    mem_data  = v.rdata;
    if (v.is_data) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    lat        = 0;
    req_cycles = 0;
    done       = 1'b0;
    first      = 1'b1;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (m_req) begin
        req_cycles++;
        if (first) begin
          first = 1'b0;
          check($sformatf("v%0d m_addr", idx), m_addr, v.addr);
          check($sformatf("v%0d m_we", idx), m_we, v.exp_we);
          check($sformatf("v%0d m_wdata", idx), m_wdata, v.exp_wdata);
        end
      end
      if (if_ready || d_ready) done = 1'b1;
      else check($sformatf("v%0d stall", idx), cpu_stall, 1);
    end
    check($sformatf("v%0d completed", idx), done, 1);
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d m_req cycles", idx), req_cycles, v.delay + 1);
    check($sformatf("v%0d served ready", idx), v.is_data ? d_ready : if_ready, 1);
    check($sformatf("v%0d other ready", idx), v.is_data ? if_ready : d_ready, 0);
    check($sformatf("v%0d bus_err", idx), bus_err, 0);
    check($sformatf("v%0d m_req done", idx), m_req, 0);
    check($sformatf("v%0d stall done", idx), cpu_stall, 0);
    check($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_if_rdata);
    check($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d_rdata);
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("v%0d ready pulse", idx), {30'h0, if_ready, d_ready}, 0);
  endtask

  initial begin
    //        data we addr          wdata         dly rdata         we wdata         if_rdata      d_rdata       lat
    vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,        2, 32'h2002_000A, 0, 32'h0,        32'h2002_000A, 32'h0,        4};
    vecs[1] = '{1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1, 32'hDEAD_BEEF, 32'h2002_000A, 32'h0,        2};
    vecs[2] = '{1, 0, 32'h0000_0044, 32'h0,        1, 32'h1234_5678, 0, 32'h0,        32'h2002_000A, 32'h1234_5678, 3};
    vecs[3] = '{1, 1, 32'h0000_0048, 32'hCAFE_F00D, 3, 32'hAAAA_AAAA, 1, 32'hCAFE_F00D, 32'h2002_000A, 32'h1234_5678, 5};
    vecs[4] = '{0, 0, 32'h0000_0104, 32'h0,        0, 32'h0050_0093, 0, 32'h0,        32'h0050_0093, 32'h1234_5678, 2};
    vecs[5] = '{0, 0, 32'h0000_0108, 32'h0,        1, 32'h00A0_0113, 0, 32'h0,        32'h00A0_0113, 32'h0,        3};

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst m_req", m_req, 0);
    check("rst m_we", m_we, 0);
    check("rst m_addr", m_addr, 0);
    check("rst m_wdata", m_wdata, 0);
    check("rst if_rdata", if_rdata, 0);
    check("rst d_rdata", d_rdata, 0);
    check("rst readies", {29'h0, if_ready, d_ready, bus_err}, 0);
    check("rst stall", cpu_stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Stray ack in IDLE must be ignored
    begin
      @(posedge clk);
      #2;
      force_ack = 1'b1;
      mem_data  = 32'hBADB_AD00;
      @(posedge clk);
      #2;
      force_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        check("stray ready", {29'h0, if_ready, d_ready, bus_err}, 0);
        check("stray m_req", m_req, 0);
        check("stray state", 32'(dut.state_q), 0);
      end
      check("stray if_rdata", if_rdata, 32'h0050_0093);
      check("stray d_rdata", d_rdata, 32'h1234_5678);
    end

    // Contention with fetch held: D,D,D,D,I,D then the leftover fetch
    begin
      bit   exp_i      [7] = '{0, 0, 0, 0, 1, 0, 1};
      int   exp_starve [7] = '{1, 2, 3, 4, 0, 1, 0};
      int   w;
      bit   is_i;
      @(negedge clk);
      mem_en    = 1'b1;
      ack_delay = 0;
      mem_data  = 32'h1111_0000;
      if_req    = 1'b1;
      if_addr   = 32'h0000_0200;
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h0000_0300;
      d_wdata   = 32'h0;
      for (int g = 0; g < 7; g++) begin
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!m_req && w < 20);
        check($sformatf("cont grant %0d seen", g), m_req, 1);
        is_i = (m_addr == 32'h0000_0200);
        check($sformatf("cont grant %0d is fetch", g), is_i, exp_i[g]);
        check($sformatf("cont starve %0d", g), 32'(dut.starve_q), exp_starve[g]);
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!(if_ready || d_ready) && w < 20);
        check($sformatf("cont ready %0d", g), is_i ? if_ready : d_ready, 1);
        @(negedge clk);
        if (!is_i) begin
          if (g == 5) d_req = 1'b0;
          else d_addr = d_addr + 32'd4;
        end else if (g == 6) begin
          if_req = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end

    // Timeout on a data read
    begin
      int lat;
      @(negedge clk);
      mem_en  = 1'b0;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0080;
      d_wdata = 32'h0;
      lat     = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!d_ready && lat < 50);
      check("tmo latency", lat, Timeout + 2);
      check("tmo d_ready", d_ready, 1);
      check("tmo bus_err", bus_err, 1);
      check("tmo d_rdata", d_rdata, 0);
      check("tmo m_req", m_req, 0);
      @(negedge clk);
      d_req  = 1'b0;
      mem_en = 1'b1;
      @(posedge clk);
      #1;
      check("tmo pulse", {30'h0, d_ready, bus_err}, 0);
      check("tmo idle", 32'(dut.state_q), 0);
      run_txn(vecs[5], 5);
    end

    // Reset during BUSY_D, pending fetch granted afterwards
    begin
      int w;
      @(negedge clk);
      mem_en = 1'b0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_0500;
      w      = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!m_req && w < 20);
      check("rmid busy", m_req, 1);
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0600;
      #2;
      rst   = 1'b1;
      d_req = 1'b0;
      #1;
      check("rmid m_req", m_req, 0);
      check("rmid m_addr", m_addr, 0);
      check("rmid m_we", m_we, 0);
      check("rmid rdata", if_rdata | d_rdata, 0);
      check("rmid readies", {29'h0, if_ready, d_ready, bus_err}, 0);
      check("rmid stall", cpu_stall, 1);
      @(negedge clk);
      rst       = 1'b0;
      mem_en    = 1'b1;
      ack_delay = 0;
      mem_data  = 32'h00C0_0193;
      @(posedge clk);
      #1;
      check("rmid regrant", m_req, 1);
      check("rmid regrant addr", m_addr, 32'h0000_0600);
      check("rmid regrant we", m_we, 0);
      @(posedge clk);
      #1;
      check("rmid if_ready", if_ready, 1);
      check("rmid if_rdata", if_rdata, 32'h00C0_0193);
      check("rmid bus_err", bus_err, 0);
      @(negedge clk);
      if_req = 1'b0;
      @(posedge clk);
      #1;
      check("rmid pulse", if_ready, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter that lets the pipelined CPU's instruction-fetch port and data port share a single unified memory with a request/acknowledge handshake. It sits between the CPU's `inst_addr`/`inst_mem` and `data_addr`/`data_mem`/`data_we`/`data_write` ports and the memory. It serialises accesses, gives data accesses priority with a starvation guard for fetch, times out hung transactions, and produces the stall signal the CPU uses to freeze its pipeline.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch is pending before fetch is forced to win (1..15).
- `TIMEOUT`, 255: cycles in BUSY without `m_ack` before the transaction is aborted (1..255).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_ready`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched word, valid when `if_ready`=1.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_ready`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, valid when `d_ready`=1 on a read.
- `d_ready` out 1: one-cycle completion pulse for data.
- `m_req` out 1: memory request, registered.
- `m_we` out 1: memory write enable, registered.
- `m_addr` out 32: memory address, registered.
- `m_wdata` out 32: memory write data, registered.
- `m_rdata` in 32: memory read data, valid with `m_ack`.
- `m_ack` in 1: memory completion, one cycle.
- `bus_err` out 1: one-cycle pulse, coincident with the ready pulse of a timed-out access.
- `cpu_stall` out 1: combinational; `(if_req & ~if_ready) | (d_req & ~d_ready)`.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- In IDLE, if neither request is present, stay in IDLE.
- In IDLE, if only `d_req` is present, go to BUSY_D.
- In IDLE, if only `if_req` is present, go to BUSY_I.
- In IDLE, if both are present, go to BUSY_D unless `starve_cnt == STARVE_LIMIT`, in which case go to BUSY_I.
- On entering BUSY_x, load the `m_*` registers from the granted port. For fetch, `m_we`=0 and `m_wdata`=0.
- BUSY_x holds `m_req`=1 and the registered `m_*` values until `m_ack`.
- On `m_ack` in BUSY_x: go to DONE. Capture `m_rdata` into `if_rdata`, or into `d_rdata` for a data read. A data write leaves `d_rdata` unchanged. Clear all `m_*` registers.
- The timeout counter increments each BUSY cycle without `m_ack`. When it reaches TIMEOUT, go to DONE, capture `32'h0` as read data, and set the error flag. `m_ack` and timeout in the same cycle count as `m_ack`, with no error.
- In DONE, pulse the served port's ready, and pulse `bus_err` if flagged. Always return to IDLE; no request is sampled in DONE.
- `starve_cnt` (4 bits):
  - increments on each data grant made while `if_req`=1;
  - clears on any fetch grant;
  - clears on a data grant made with `if_req`=0;
  - saturates at STARVE_LIMIT.
- `m_ack` outside BUSY is ignored.
- Changes on requester inputs during BUSY are ignored, because the `m_*` values are registered.

## Timing
- Reset values (asynchronous, immediate): state IDLE, and every output register 0 (`m_req`, `m_we`, `m_addr`, `m_wdata`, `if_rdata`, `d_rdata`, `if_ready`, `d_ready`, `bus_err`). `starve_cnt` and the timeout counter are also 0.
- Reset mid-transaction drops `m_req` immediately and abandons the access; no ready pulse follows.
- Request seen at edge N (IDLE) -> `m_req`=1 from edge N+1.
- `m_ack` sampled at edge N+1+k -> ready=1 for the cycle after edge N+2+k.
- Minimum access is 3 cycles (IDLE, BUSY, DONE), with k=0 when memory acks in its first BUSY cycle.
- Back-to-back accesses are separated by the DONE->IDLE cycle.
- Timeout: ready and `bus_err` come TIMEOUT+1 cycles after BUSY entry.

## Test plan
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x100, memory acks after 2 BUSY cycles with 0x2002000A.
  - Required: `m_addr`=0x100, `m_we`=0; `if_ready` pulses once with `if_rdata`=0x2002000A; `cpu_stall` high until that cycle.
- Data write:
  - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, immediate ack.
  - Required: `m_we`=1 with those values for exactly 1 cycle; `d_ready` 2 cycles after the request is sampled; `d_rdata` unchanged.
- Contention and starvation (STARVE_LIMIT=4):
  - Stimulus: `if_req` held high while `d_req` is re-asserted after every `d_ready`.
  - Required: grants go D, D, D, D, I, then D resumes; `starve_cnt` returns to 0 after the I grant.
- Timeout (TIMEOUT=8):
  - Stimulus: `d_req` read, `m_ack` never asserted.
  - Required: `d_ready` and `bus_err` pulse together, `d_rdata`=0, state returns to IDLE; a following fetch completes normally.
- Reset mid-operation:
  - Stimulus: assert `rst` during BUSY_D.
  - Required: `m_req`=0 in the same cycle, all outputs 0; after release, a pending `if_req` is granted from IDLE.
- Stray ack:
  - Stimulus: `m_ack` pulsed in IDLE.
  - Required: no ready pulse and no state change.
